// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests, and an
// in-order response queue presented to decode on a valid/ready handshake, flushed by redirects.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_err_o
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    entry_t             q_mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   occupancy;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;
    logic [31:0]        fetch_pc;
    logic [31:0]        resp_pc;

    logic               grant;
    logic               rsp_drop;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     credit_used;
    logic [31:0]        redirect_target;
    logic               unused_pc_lsb;
    entry_t             head_entry;

    assign redirect_target = {redirect_pc_i[31:2], 2'b00};
    assign unused_pc_lsb   = ^redirect_pc_i[1:0];

    // Grants still to be dropped hold credit too, so a response always finds a free slot.
    assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};

    // NOTE: outputs are gated by rst_n combinationally so they read 0 for the whole reset
    // window, not just from the first reset edge onward.
    assign imem_req_o  = rst_n && !redirect_i && (credit_used < DEPTH_C);
    assign imem_addr_o = fetch_pc;

    assign grant    = imem_req_o && imem_gnt_i;
    assign rsp_drop = (drop_cnt != '0);
    assign push     = rst_n && imem_rvalid_i && !rsp_drop && !redirect_i;
    assign pop      = inst_valid_o && inst_ready_i;

    assign head_entry   = q_mem[head];
    assign inst_valid_o = rst_n && (occupancy != '0);
    assign inst_err_o   = rst_n && head_entry.err;
    assign inst_o       = !rst_n ? 32'h0 : (head_entry.err ? NOP : head_entry.inst);
    assign pc_o         = rst_n ? head_entry.pc : 32'h0;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_i) begin
            // No grant is possible this cycle, so only a same-cycle response shrinks the count.
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            head        <= '0;
            tail        <= '0;
            occupancy   <= '0;
            outstanding <= outstanding - CNT_W'(imem_rvalid_i);
            drop_cnt    <= outstanding - CNT_W'(imem_rvalid_i);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
            if (imem_rvalid_i && rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (push) begin
                tail    <= tail + 1'b1;
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: queue storage has no reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[tail] <= '{inst: imem_rdata_i, pc: resp_pc, err: imem_err_i};
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: an in-order memory model with random latency feeds the DUT,
// a token-level fetch model predicts request/address, and a monitor checks every decode handshake.
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_err_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_err_o;

    always #5 clk = ~clk;

    inst_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_err_i   (imem_err_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .inst_err_o   (inst_err_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
        logic        err;
    } mem_txn_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    mem_txn_t    mem_q[$];
    exp_t        sb[$];

    int          n_checks = 0;
    int          n_fail   = 0;

    // Stimulus knobs
    int          gnt_pct  = 100;
    int          rdy_pct  = 100;
    int          lat_min  = 0;
    int          lat_max  = 0;
    int          redir_pm = 0;
    int          err_pct  = 0;
    int          rst_pm   = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit          rst_cmd  = 1'b1;
    bit          force_redirect = 1'b0;
    logic [31:0] force_target = '0;

    // Reference model state
    int          cyc      = 0;
    int          epoch    = 0;
    int          owed     = 0;
    logic [31:0] model_pc = RESET_PC;

    // Values sampled mid-cycle by the driver
    bit          s_req, s_valid, s_grant, s_err;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[7:0], addr[31:8]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        int  stale;
        bit  exp_req;
        bit  pop;
        bit  err;
        int  lat;
        @(negedge clk);
        if (rst_pm != 0) rst_cmd = ($urandom_range(999) < rst_pm);
        rst_n = !rst_cmd;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        imem_err_i    = 1'b0;
        if (rst_n && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0].addr);
            imem_err_i    = mem_q[0].err;
        end
        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        inst_ready_i  = ($urandom_range(99) < rdy_pct);
        redirect_i    = rst_n && (force_redirect || ($urandom_range(999) < redir_pm));
        redirect_pc_i = force_redirect ? force_target : $urandom;
        #2;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = inst_valid_o;
        s_pc    = pc_o;
        s_inst  = inst_o;
        s_err   = inst_err_o;
        if (!rst_n) begin
            check("reset_req", imem_req_o, 0);
            check("reset_valid", inst_valid_o, 0);
            check("reset_err", inst_err_o, 0);
            check("reset_inst", inst_o, 0);
            check("reset_pc", pc_o, 0);
        end else begin
            stale = 0;
            foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
            exp_req = !redirect_i && (owed + stale < DEPTH);
            check("imem_req_o", imem_req_o, exp_req);
            if (imem_req_o) check("imem_addr_o", imem_addr_o, model_pc);
        end
        pop     = rst_n && inst_valid_o && inst_ready_i && !redirect_i;
        s_grant = rst_n && imem_req_o && imem_gnt_i;
        @(posedge clk);
        if (!rst_n) begin
            mem_q.delete();
            sb.delete();
            owed     = 0;
            model_pc = RESET_PC;
            epoch++;
        end else begin
            if (imem_rvalid_i) void'(mem_q.pop_front());
            if (redirect_i) begin
                epoch++;
                sb.delete();
                owed     = 0;
                model_pc = {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (pop) owed--;
                if (s_grant) begin
                    err = (model_pc == err_addr) || ($urandom_range(99) < err_pct);
                    lat = $urandom_range(lat_max, lat_min);
                    mem_q.push_back('{addr: model_pc, due: cyc + 1 + lat, epoch: epoch, err: err});
                    sb.push_back('{pc: model_pc, inst: err ? NOP : mem_word(model_pc), err: err});
                    owed++;
                    model_pc = model_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    // Monitor: pops the scoreboard on every decode handshake and checks head stability.
    initial begin
        bit          pv = 1'b0;
        bit          pr = 1'b0;
        bit          pd = 1'b0;
        logic [31:0] ppc = '0;
        logic [31:0] pinst = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && pv && !pr && !pd) begin
                check("hold_valid", inst_valid_o, 1);
                check("hold_pc", pc_o, ppc);
                check("hold_inst", inst_o, pinst);
            end
            if (rst_n && inst_valid_o && inst_ready_i && !redirect_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got pc %h expected no valid head", pc_o);
                end else begin
                    e = sb.pop_front();
                    check("pop_pc", pc_o, e.pc);
                    check("pop_inst", inst_o, e.inst);
                    check("pop_err", inst_err_o, e.err);
                end
            end
            pv    = rst_n && inst_valid_o;
            pr    = inst_ready_i;
            pd    = redirect_i;
            ppc   = pc_o;
            pinst = inst_o;
        end
    end

    task automatic do_reset(input int n);
        rst_cmd = 1'b1;
        repeat (n) cycle();
        rst_cmd = 1'b0;
    endtask

    initial begin
        int          grants;
        bit          found;
        logic [31:0] prev_addr;

        // Reset, then zero-wait streaming: valid from the third cycle, no bubbles.
        do_reset(3);
        for (int k = 0; k < 66; k++) begin
            cycle();
            check(k >= 2 ? "stream_valid" : "startup_valid", s_valid, k >= 2);
        end

        // Decode stalled: exactly DEPTH grants, then resume at 0x10.
        do_reset(2);
        rdy_pct = 0;
        grants  = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_grant) grants++;
        end
        check("stall_grants", grants, DEPTH);
        check("stall_req_low", s_req, 0);
        rdy_pct = 100;
        found   = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (s_grant) begin
                found = 1'b1;
                check("resume_addr", s_addr, 32'h10);
            end
        end
        check("resume_seen", found, 1);

        // Two grants in flight at 3-cycle latency, then redirect to an unaligned target.
        do_reset(2);
        lat_min = 3;
        lat_max = 3;
        repeat (2) cycle();
        force_redirect = 1'b1;
        force_target   = 32'h8000_0102;
        cycle();
        force_redirect = 1'b0;
        check("redirect_req_low", s_req, 0);
        cycle();
        check("post_redirect_grant", s_grant, 1);
        check("post_redirect_addr", s_addr, 32'h8000_0100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (s_valid) begin
                found = 1'b1;
                check("post_redirect_pc", s_pc, 32'h8000_0100);
            end
        end
        check("post_redirect_valid_seen", found, 1);

        // Redirect coinciding with a response and a pop.
        lat_min = 0;
        lat_max = 0;
        do_reset(2);
        repeat (6) cycle();
        force_redirect = 1'b1;
        force_target   = 32'h0000_0200;
        cycle();
        force_redirect = 1'b0;
        check("redirect_cycle_valid", s_valid, 1);
        cycle();
        check("flushed_valid", s_valid, 0);
        repeat (10) cycle();

        // Bus error on 0x0C: NOP with error flag at the head.
        do_reset(2);
        err_addr = 32'h0000_000C;
        found    = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (s_valid && s_pc == 32'h0000_000C) begin
                found = 1'b1;
                check("err_flag", s_err, 1);
                check("err_nop", s_inst, NOP);
            end
        end
        check("err_seen", found, 1);
        err_addr = 32'hFFFF_FFFF;

        // PC wrap at the top of the address space, then reset mid-stream.
        force_redirect = 1'b1;
        force_target   = 32'hFFFF_FFF8;
        cycle();
        force_redirect = 1'b0;
        found     = 1'b0;
        prev_addr = '0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (s_grant) begin
                if (s_addr == 32'h0 && prev_addr == 32'hFFFF_FFFC) found = 1'b1;
                prev_addr = s_addr;
            end
        end
        check("wrap_seen", found, 1);
        do_reset(2);
        cycle();
        check("restart_addr", s_addr, RESET_PC);
        repeat (10) cycle();

        // Randomized traffic with redirects, errors, stalls and occasional resets.
        gnt_pct  = 60;
        rdy_pct  = 70;
        lat_max  = 4;
        redir_pm = 30;
        err_pct  = 5;
        rst_pm   = 2;
        repeat (3000) cycle();
        rst_pm = 0;
        rst_cmd = 1'b0;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
